rate_enable_gen: RTL and testbench

Upstream pacing stage for the 8-bit T-flip-flop display counter. It produces a one-cycle enable pulse that drives that counter's En input, so the HEX display advances at a human-visible rate. The rate is selectable from switches. A pause mode allows the count to be advanced one step at a time from a pushbutton.

---
 rtl/rate_enable_gen.sv | 91 +++++++++
 tb/tb_rate_enable_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rate_enable_gen.sv
// Pacing stage that emits a one-cycle enable pulse at a switch-selected rate,
// with a paused mode where a synchronised pushbutton advances one step at a time.
module rate_enable_gen #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned CW     = 28
) (
  input  logic       C,
  input  logic       Clr,
  input  logic [1:0] Sel,
  input  logic       Run,
  input  logic       Step,
  output logic       Pulse,
  output logic       Running
);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_e;

  localparam logic [63:0]   HZ    = 64'(CLK_HZ);
  localparam logic [CW-1:0] RLD_1 = CW'(HZ - 64'd1);
  localparam logic [CW-1:0] RLD_2 = CW'((64'd2 * HZ) - 64'd1);
  localparam logic [CW-1:0] RLD_4 = CW'((64'd4 * HZ) - 64'd1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          pulse_q, pulse_d;
  logic          s1_q, s2_q, s3_q;
  logic          step_rise;

  function automatic logic [CW-1:0] reload(input logic [1:0] s);
    case (s)
      2'b00:   return '0;
      2'b01:   return RLD_1;
      2'b10:   return RLD_2;
      default: return RLD_4;
    endcase
  endfunction

  always_ff @(posedge C or posedge Clr) begin
    if (Clr) begin
      state_q <= PAUSED;
      cnt_q   <= '0;
      sel_q   <= '0;
      pulse_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pulse_q <= pulse_d;
      s1_q    <= Step;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign step_rise = s2_q & ~s3_q;

  // Counter and pulse act on the live Run switch; the state register only
  // mirrors it for the status LED.
  always_comb begin
    state_d = Run ? RUNNING : PAUSED;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pulse_d = 1'b0;
    if (Sel != sel_q) begin
      cnt_d = reload(Sel);
      sel_d = Sel;
    end else if (Run) begin
      if (cnt_q == '0) begin
        pulse_d = 1'b1;
        cnt_d   = reload(sel_q);
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      pulse_d = step_rise;
    end
  end

  always_comb begin
    Running = (state_q == RUNNING);
    Pulse   = pulse_q;
  end

endmodule

// File: tb/tb_rate_enable_gen.sv
// Directed and randomized bench for rate_enable_gen; a reference model tracks
// edges-until-next-pulse and the sampled Step history.
module tb_rate_enable_gen;

  localparam int CLK_HZ = 4;
  localparam int CW     = 5;

  logic       C = 1'b0;
  logic       Clr;
  logic [1:0] Sel;
  logic       Run;
  logic       Step;
  logic       Pulse;
  logic       Running;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt;

  logic [1:0] m_sel;
  int         m_togo;
  logic       m_pulse;
  logic       m_run;
  logic [2:0] m_hist;

  rate_enable_gen #(.CLK_HZ(CLK_HZ), .CW(CW)) dut (
    .C(C), .Clr(Clr), .Sel(Sel), .Run(Run), .Step(Step),
    .Pulse(Pulse), .Running(Running)
  );

  always #5 C = ~C;

  function automatic int n_of(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CLK_HZ;
      2'b10:   return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel   = 2'b00;
    m_togo  = 1;
    m_pulse = 1'b0;
    m_run   = 1'b0;
    m_hist  = 3'b000;
  endtask

  // m_togo = edges until the next pulse while running; a step pulse fires two
  // edges after Step is first seen high at a clock edge.
  task automatic model_edge();
    logic rise;
    rise = m_hist[1] & ~m_hist[2];
    if (Sel != m_sel) begin
      m_sel   = Sel;
      m_togo  = n_of(Sel);
      m_pulse = 1'b0;
    end else if (Run) begin
      m_togo--;
      if (m_togo == 0) begin
        m_pulse = 1'b1;
        m_togo  = n_of(m_sel);
      end else begin
        m_pulse = 1'b0;
      end
    end else begin
      m_pulse = rise;
    end
    m_hist = {m_hist[1:0], Step};
    m_run  = Run;
  endtask

  task automatic cyc(input string tag);
    @(posedge C);
    if (Clr) model_reset();
    else     model_edge();
    @(negedge C);
    check({tag, ".pulse"}, Pulse, m_pulse);
    check({tag, ".running"}, Running, m_run);
    if (Pulse) pulse_cnt++;
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    Clr = 1'b1; Sel = 2'b01; Run = 1'b1; Step = 1'b0;
    model_reset();
    #1;
    check("reset.pulse", Pulse, 1'b0);
    check("reset.running", Running, 1'b0);
    cycles(2, "reset_hold");

    // Periodic 1 Hz: reload at edge 1, pulses after edges 5, 9, 13, 17
    @(negedge C);
    Clr = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      cyc("periodic");
      check("periodic.const", Pulse, (e == 5 || e == 9 || e == 13 || e == 17));
    end

    // Async clear while Pulse is high
    #2 Clr = 1'b1;
    #1;
    model_reset();
    check("clr_mid.pulse", Pulse, 1'b0);
    check("clr_mid.running", Running, 1'b0);
    cycles(3, "clr_held");

    // Full speed from reset, then switch to 0.25 Hz
    @(negedge C);
    Sel = 2'b00; Run = 1'b1; Clr = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      cyc("fullspeed");
      check("fullspeed.const", Pulse, 1'b1);
    end
    Sel = 2'b11;
    pulse_cnt = 0;
    for (int e = 0; e <= 40; e++) begin
      cyc("quarter");
      check("quarter.const", Pulse, (e == 16 || e == 32));
    end

    // Pause at Cnt=5 with N=8, resume after 20 cycles
    Sel = 2'b10;
    cycles(3, "pause_lead");
    Run = 1'b0;
    pulse_cnt = 0;
    cycles(20, "paused");
    check_int("paused.count", pulse_cnt, 0);
    Run = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      cyc("resume");
      check("resume.const", Pulse, (e == 6 || e == 14 || e == 22));
    end

    // Single step: three presses, then one long hold
    Run = 1'b0;
    cycles(3, "step_lead");
    pulse_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      Step = 1'b1;
      for (int e = 1; e <= 5; e++) begin
        cyc("step");
        check("step.const", Pulse, (e == 3));
      end
      Step = 1'b0;
      cycles(5, "step_low");
    end
    check_int("step.count", pulse_cnt, 3);
    pulse_cnt = 0;
    Step = 1'b1;
    cycles(50, "step_hold");
    Step = 1'b0;
    cycles(5, "step_release");
    check_int("step_hold.count", pulse_cnt, 1);

    // Step toggling is ignored while running at 1 Hz
    Run = 1'b1; Sel = 2'b01;
    cyc("ignore_reload");
    pulse_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e % 2 == 1) Step = ~Step;
      cyc("ignore");
      check("ignore.const", Pulse, (e % 4 == 0));
    end
    check_int("ignore.count", pulse_cnt, 10);

    // Randomized switch activity with occasional async clears
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) Sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 23) == 0) Run = ~Run;
      if ($urandom_range(0, 3) == 0)  Step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 Clr = 1'b1;
        #1;
        model_reset();
        check("rand_clr.pulse", Pulse, 1'b0);
        check("rand_clr.running", Running, 1'b0);
        cyc("rand_clr_held");
        Clr = 1'b0;
      end
      cyc("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
